// File: rtl/hba_arbiter_if.sv
// ---------------------------------------------------------------------------
// hba_arbiter_if
// Bundles the master-side request/transfer fields, the muxed slave-side bus
// and the watchdog status of the HBA arbiter.
//   master modport : the arbiter's view (takes requests and slave responses,
//                    drives grant, the muxed bus, the ack/read data to the
//                    masters and the error flag)
//   slave modport  : the environment's view (the opposite directions)
// Signals:
//   master_request / hba_mgrant                  request / one-hot grant
//   master_{abus,rnw,select,dbus}_all            packed per-master fields
//   hba_{abus,rnw,select,dbus}                   muxed bus to the slaves
//   hba_xferack_slave / hba_dbus_slave           OR of the slave responses
//   hba_xferack / hba_dbus_rd                    response to the masters
//   timeout_err / err_clear                      sticky watchdog error
// ---------------------------------------------------------------------------
interface hba_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int DBUS_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12
);
    logic [NUM_MASTERS-1:0]            master_request;
    logic [NUM_MASTERS-1:0]            hba_mgrant;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus_all;
    logic [NUM_MASTERS-1:0]            master_rnw_all;
    logic [NUM_MASTERS-1:0]            master_select_all;
    logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus_all;
    logic [ADDR_WIDTH-1:0]             hba_abus;
    logic                              hba_rnw;
    logic                              hba_select;
    logic [DBUS_WIDTH-1:0]             hba_dbus;
    logic                              hba_xferack_slave;
    logic [DBUS_WIDTH-1:0]             hba_dbus_slave;
    logic                              hba_xferack;
    logic [DBUS_WIDTH-1:0]             hba_dbus_rd;
    logic                              timeout_err;
    logic                              err_clear;

    modport master (
        input  master_request, master_abus_all, master_rnw_all,
               master_select_all, master_dbus_all,
               hba_xferack_slave, hba_dbus_slave, err_clear,
        output hba_mgrant, hba_abus, hba_rnw, hba_select, hba_dbus,
               hba_xferack, hba_dbus_rd, timeout_err
    );

    modport slave (
        output master_request, master_abus_all, master_rnw_all,
               master_select_all, master_dbus_all,
               hba_xferack_slave, hba_dbus_slave, err_clear,
        input  hba_mgrant, hba_abus, hba_rnw, hba_select, hba_dbus,
               hba_xferack, hba_dbus_rd, timeout_err
    );
endinterface

// File: rtl/hba_arbiter.sv
// ---------------------------------------------------------------------------
// hba_arbiter
// Round-robin arbiter plus bus multiplexer letting NUM_MASTERS HBA masters
// share one HBA slave bus, with a per-transfer watchdog that completes a
// transfer with an error when no slave acknowledges within XFER_TIMEOUT
// cycles.
// Ports:
//   hba_clk    : bus clock, rising edge
//   hba_reset  : asynchronous active-low reset
//   bus        : hba_arbiter_if.master (requests, grant, muxed bus,
//                slave responses, ack/read data, timeout_err/err_clear)
// ---------------------------------------------------------------------------
module hba_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int DBUS_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int XFER_TIMEOUT = 64
) (
    input  logic          hba_clk,
    input  logic          hba_reset,
    hba_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CNT_W = $clog2(XFER_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]       CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [IDX_W:0]         pick_s;
    logic                   owner_req_s;
    logic                   owner_sel_s;
    logic [ADDR_WIDTH-1:0]  abus_s;
    logic                   rnw_s;
    logic                   select_s;
    logic [DBUS_WIDTH-1:0]  dbus_s;
    logic                   timeout_hit_s;

    // Round-robin pick: {found, index} of the first requester at ptr, ptr+1, ...
    // Scanned from the far end so the lowest offset from ptr is written last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] sel;
        int               idx;
        res = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end else begin
                idx = idx;
            end
            sel = IDX_W'(idx);
            if (req[sel]) begin
                res = {1'b1, sel};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign pick_s      = rr_pick(bus.master_request, ptr_q);
    assign owner_req_s = bus.master_request[owner_q];
    assign owner_sel_s = bus.master_select_all[owner_q];

    // State register: FSM, grant, owner, rr pointer, watchdog counter, error flag.
    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: grant in IDLE, release when owner is fully quiet.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[IDX_W]) begin
                    state_d = ST_GRANTED;
                    owner_d = pick_s[IDX_W-1:0];
                    grant_d = ONE_HOT0 << pick_s[IDX_W-1:0];
                end else begin
                    grant_d = '0;
                end
            end
            ST_GRANTED: begin
                // A dropped request with select still high keeps the grant
                // until the transfer is acked or timed out.
                if (!owner_req_s && !owner_sel_s) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);
                end else begin
                    grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic: bus mux from the grant register; idle bus is all zeros.
    always_comb begin
        abus_s   = '0;
        rnw_s    = 1'b0;
        select_s = 1'b0;
        dbus_s   = '0;
        if (grant_q != '0) begin
            abus_s   = bus.master_abus_all[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
            rnw_s    = bus.master_rnw_all[owner_q];
            select_s = bus.master_select_all[owner_q];
            dbus_s   = bus.master_dbus_all[int'(owner_q)*DBUS_WIDTH +: DBUS_WIDTH];
        end else begin
            abus_s   = '0;
        end
    end

    // Timeout only fires without a slave ack, so a same-cycle ack wins.
    assign timeout_hit_s = select_s && !bus.hba_xferack_slave && (cnt_q == CNT_LAST);

    // Watchdog next state: count unacked select cycles, saturate, clear on end.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (!select_s || bus.hba_xferack_slave || timeout_hit_s) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // Setting has priority over a simultaneous clear.
        if (timeout_hit_s) begin
            err_d = 1'b1;
        end else if (bus.err_clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign bus.hba_mgrant  = grant_q;
    assign bus.hba_abus    = abus_s;
    assign bus.hba_rnw     = rnw_s;
    assign bus.hba_select  = select_s;
    assign bus.hba_dbus    = dbus_s;
    assign bus.hba_xferack = bus.hba_xferack_slave | timeout_hit_s;
    assign bus.hba_dbus_rd = timeout_hit_s ? '0 : bus.hba_dbus_slave;
    assign bus.timeout_err = err_q;

endmodule
